pb_event_rx: RTL and testbench

- Input-side receiver for the two player pushbuttons: synchronizes, debounces and edge-detects the raw left/right buttons.
- Presents each press as a single held event with a valid/ack handshake to the round logic (scorer / round arbiter consumer).
- Complements the LED/speaker output path: turns noisy physical inputs into clean, one-per-press events.
- Runs on the divided game clock.

---
 rtl/pb_event_rx_if.sv | 27 ++
 rtl/pb_event_rx.sv | 152 +++++++++++++++
 tb/tb_pb_event_rx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pb_event_rx_if.sv
// Event handshake bundle between the pushbutton receiver and the round logic.
//   ack        consumer -> receiver : accept the pending event
//   evt_valid  receiver -> consumer : an event is pending (held until ack)
//   evt_right  receiver -> consumer : 1 = right won, 0 = left won
//   evt_tie    receiver -> consumer : both buttons pressed on the same cycle
//   pbl_level  receiver -> consumer : debounced left level
//   pbr_level  receiver -> consumer : debounced right level
//   drop_cnt   receiver -> consumer : presses dropped while busy
interface pb_event_rx_if;
  logic       ack;
  logic       evt_valid;
  logic       evt_right;
  logic       evt_tie;
  logic       pbl_level;
  logic       pbr_level;
  logic [7:0] drop_cnt;

  modport master (
    input  ack,
    output evt_valid, evt_right, evt_tie, pbl_level, pbr_level, drop_cnt
  );

  modport slave (
    output ack,
    input  evt_valid, evt_right, evt_tie, pbl_level, pbr_level, drop_cnt
  );
endinterface

// File: rtl/pb_event_rx.sv
// Pushbutton event receiver: synchronizes, debounces and edge-detects the two
// player buttons and presents each press as one held event with valid/ack.
// Ports:
//   clk      game clock (divided), rising edge
//   rst      asynchronous active-high reset
//   pbl_raw  raw left button (1 = pressed)
//   pbr_raw  raw right button (1 = pressed)
//   evt      pb_event_rx_if.master (ack in; evt_valid/right/tie, levels, drop_cnt out)
// Optional build macro: PB_DROP_COUNT_EN enables the saturating dropped-press
// counter; without it drop_cnt is tied to 0.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | no event outstanding, waiting for a debounced press
// PENDING | event presented on evt_valid, waiting for ack
// LOCKOUT | acked; waiting for both buttons released before rearming
module pb_event_rx #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pbl_raw,
  input  logic          pbr_raw,
  pb_event_rx_if.master evt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  // Index 0 = left button, index 1 = right button.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       level_q, level_d;
  logic [1:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t state_q, state_d;
  logic   right_q, right_d;
  logic   tie_q, tie_d;

  // Counter runs only while the synchronized input disagrees with the level;
  // reaching DEB_CYCLES flips the level, so shorter glitches never register.
  always_comb begin
    level_d = level_q;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (cnt_q[b] == CNT_W'(DEB_CYCLES - 1)) begin
          level_d[b] = ~level_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= {pbr_raw, pbl_raw};
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      right_q <= 1'b0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      right_q <= right_d;
      tie_q   <= tie_d;
    end
  end

  always_comb begin
    state_d = state_q;
    right_d = right_q;
    tie_d   = tie_q;
    unique case (state_q)
      S_IDLE: begin
        if (|press_q) begin
          state_d = S_PENDING;
          tie_d   = &press_q;
          right_d = press_q[1] & ~press_q[0];
        end
      end
      S_PENDING: begin
        if (evt.ack) begin
          state_d = S_LOCKOUT;
          right_d = 1'b0;
          tie_d   = 1'b0;
        end
      end
      S_LOCKOUT: begin
        if (level_q == 2'b00) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        right_d = 1'b0;
        tie_d   = 1'b0;
      end
    endcase
  end

  assign evt.evt_valid = (state_q == S_PENDING);
  assign evt.evt_right = right_q;
  assign evt.evt_tie   = tie_q;
  assign evt.pbl_level = level_q[0];
  assign evt.pbr_level = level_q[1];

`ifdef PB_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  always_comb begin
    drop_inc = {1'b0, press_q[0]} + {1'b0, press_q[1]};
    drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
    drop_d   = drop_q;
    if (state_q != S_IDLE) begin
      drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign evt.drop_cnt = drop_q;
`else
  assign evt.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pb_event_rx.sv
// Scoreboard bench for pb_event_rx: stimulus pushes expected events (winner,
// tie, edge on which evt_valid must first appear); a monitor pops and checks
// every rising of evt_valid.
module tb_pb_event_rx;

  typedef struct {
    logic right;
    logic tie;
    int   edge_no;
  } exp_evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pbl_raw = 1'b0;
  logic pbr_raw = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic prev_v = 1'b0;
  exp_evt_t exp_q[$];

  pb_event_rx_if bus ();

  pb_event_rx #(.DEB_CYCLES(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .pbl_raw (pbl_raw),
    .pbr_raw (pbr_raw),
    .evt     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each new event is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (bus.evt_valid && !prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got right=%0b tie=%0b at edge %0d, required no event",
                   bus.evt_right, bus.evt_tie, cyc);
        end else begin
          exp_evt_t e;
          e = exp_q.pop_front();
          if (bus.evt_right !== e.right || bus.evt_tie !== e.tie || cyc != e.edge_no) begin
            fails++;
            $display("FAIL event: got right=%0b tie=%0b edge=%0d, required right=%0b tie=%0b edge=%0d",
                     bus.evt_right, bus.evt_tie, cyc, e.right, e.tie, e.edge_no);
          end
        end
      end
      prev_v <= bus.evt_valid;
    end
  end

  task automatic push_evt(input logic right, input logic tie, input int t0);
    exp_evt_t e;
    e.right = right;
    e.tie = tie;
    e.edge_no = t0 + 19;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.evt_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.evt_valid) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got evt_valid=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  task automatic settle();
    pbl_raw = 1'b0;
    pbr_raw = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_drop(input logic [7:0] n);
`ifdef PB_DROP_COUNT_EN
    return n;
`else
    return 8'd0 & n;
`endif
  endfunction

  initial begin
    int t0;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", {7'b0, bus.evt_valid}, 8'd0);
    chk("reset_right", {7'b0, bus.evt_right}, 8'd0);
    chk("reset_tie",   {7'b0, bus.evt_tie}, 8'd0);
    chk("reset_lvl_l", {7'b0, bus.pbl_level}, 8'd0);
    chk("reset_lvl_r", {7'b0, bus.pbr_level}, 8'd0);
    chk("reset_drop",  bus.drop_cnt, 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Right press: level at edge 18, event at edge 19, held until ack.
    t0 = cyc;
    pbr_raw = 1'b1;
    push_evt(1'b1, 1'b0, t0);
    repeat (17) @(negedge clk);
    chk("r_level_e17", {7'b0, bus.pbr_level}, 8'd0);
    @(negedge clk);
    chk("r_level_e18", {7'b0, bus.pbr_level}, 8'd1);
    wait_valid("right", 5);
    repeat (5) @(negedge clk);
    chk("r_held", {7'b0, bus.evt_valid}, 8'd1);
    do_ack();
    chk("r_acked_valid", {7'b0, bus.evt_valid}, 8'd0);
    chk("r_acked_right", {7'b0, bus.evt_right}, 8'd0);
    settle();

    // 10-cycle glitch on left must not change level or make an event.
    pbl_raw = 1'b1;
    repeat (10) @(negedge clk);
    pbl_raw = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_level", {7'b0, bus.pbl_level}, 8'd0);
    repeat (25) @(negedge clk);
    chk("glitch_valid", {7'b0, bus.evt_valid}, 8'd0);

    // Simultaneous press gives a tie; lockout until both released.
    t0 = cyc;
    pbl_raw = 1'b1;
    pbr_raw = 1'b1;
    push_evt(1'b0, 1'b1, t0);
    wait_valid("tie", 25);
    chk("tie_flag", {7'b0, bus.evt_tie}, 8'd1);
    do_ack();
    chk("tie_acked", {7'b0, bus.evt_tie}, 8'd0);
    pbr_raw = 1'b0;
    repeat (25) @(negedge clk);
    chk("tie_lockout", {7'b0, bus.evt_valid}, 8'd0);
    settle();
    t0 = cyc;
    pbl_raw = 1'b1;
    push_evt(1'b0, 1'b0, t0);
    wait_valid("left_after_tie", 25);
    do_ack();
    settle();

    // Right press while left pending is dropped.
    t0 = cyc;
    pbl_raw = 1'b1;
    push_evt(1'b0, 1'b0, t0);
    wait_valid("left_pending", 25);
    pbr_raw = 1'b1;
    repeat (25) @(negedge clk);
    chk("drop_still_left", {7'b0, bus.evt_right}, 8'd0);
    chk("drop_still_valid", {7'b0, bus.evt_valid}, 8'd1);
    do_ack();
    chk("drop_cnt_1", bus.drop_cnt, exp_drop(8'd1));
    settle();

    // Left held through ack, released 20 cycles, pressed again.
    t0 = cyc;
    pbl_raw = 1'b1;
    push_evt(1'b0, 1'b0, t0);
    wait_valid("hold_first", 25);
    do_ack();
    repeat (10) @(negedge clk);
    pbl_raw = 1'b0;
    repeat (20) @(negedge clk);
    t0 = cyc;
    pbl_raw = 1'b1;
    push_evt(1'b0, 1'b0, t0);
    wait_valid("hold_repress", 25);
    do_ack();
    chk("drop_cnt_still_1", bus.drop_cnt, exp_drop(8'd1));
    settle();

    // Asynchronous reset while an event is pending with the button held.
    t0 = cyc;
    pbr_raw = 1'b1;
    push_evt(1'b1, 1'b0, t0);
    wait_valid("pre_reset", 25);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", {7'b0, bus.evt_valid}, 8'd0);
    chk("async_right", {7'b0, bus.evt_right}, 8'd0);
    chk("async_level", {7'b0, bus.pbr_level}, 8'd0);
    chk("async_drop",  bus.drop_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    push_evt(1'b1, 1'b0, t0);
    wait_valid("post_reset", 25);
    do_ack();
    settle();

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
